// File: rtl/pwm_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_generator : double-buffered PWM source, period/high time in clk cycles |
// | Optional sync_pulse output enabled by defining PWM_SYNC_OUT_EN.            |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module pwm_generator #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] duty_in,
  input  logic [CNT_W-1:0] period_in,
  output logic             busy,
`ifdef PWM_SYNC_OUT_EN
  output logic             sync_pulse,
`endif
  output logic             pwm_out
);

  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_act_period;
  logic [CNT_W-1:0] r_act_duty;
  logic [CNT_W-1:0] r_sh_period;
  logic [CNT_W-1:0] r_sh_duty;
  logic             r_pending;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pwm;

  logic w_period_zero;
  logic w_last;
  logic w_boundary;
  logic w_apply;
  logic w_pwm_next;

  assign w_period_zero = (r_act_period == '0);
  assign w_last        = (r_cnt == (r_act_period - c_one));
  assign w_boundary    = !enable || w_period_zero || w_last;
  assign w_apply       = w_boundary && r_pending;
  assign w_pwm_next    = enable && !w_period_zero && (r_cnt < r_act_duty);

  // A load coinciding with an apply keeps pending set so the new pair waits a period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh_period <= '0;
      r_sh_duty   <= '0;
      r_pending   <= 1'b0;
    end else if (load) begin
      r_sh_period <= period_in;
      r_sh_duty   <= duty_in;
      r_pending   <= 1'b1;
    end else if (w_apply) begin
      r_pending   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act_period <= '0;
      r_act_duty   <= '0;
    end else if (w_apply) begin
      r_act_period <= r_sh_period;
      r_act_duty   <= r_sh_duty;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_boundary) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_one;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= w_pwm_next;
    end
  end

  assign busy    = r_pending;
  assign pwm_out = r_pwm;

`ifdef PWM_SYNC_OUT_EN
  logic r_sync;
  logic w_sync_next;

  assign w_sync_next = enable && !w_period_zero && (r_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= 1'b0;
    end else begin
      r_sync <= w_sync_next;
    end
  end

  assign sync_pulse = r_sync;
`endif

endmodule
`default_nettype wire
